// File: rtl/digdug_cusio_master.sv
// Bus master for the Dig Dug custom I/O chip: command write, wait for the chip's
// NMI, burst LEN reads/writes through local buffers, then disable the NMI with STOP_CMD.
module digdug_cusio_master #(
  parameter logic [7:0]  STOP_CMD    = 8'h10,
  parameter int unsigned NMI_TIMEOUT = 4095
) (
  input  logic       CL,
  input  logic       RESET,
  input  logic       REQ,
  input  logic [7:0] CMD,
  input  logic [3:0] LEN,
  input  logic       DIR,
  input  logic       WWE,
  input  logic [3:0] WADR,
  input  logic [7:0] WDAT,
  input  logic [3:0] RADR,
  output logic [7:0] RDAT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       IO_CS,
  output logic       IO_WR,
  output logic [4:0] IO_AD,
  output logic [7:0] IO_DO,
  input  logic [7:0] IO_DI,
  input  logic       IO_NMI
);

  localparam int unsigned TW     = (NMI_TIMEOUT < 2) ? 1 : $clog2(NMI_TIMEOUT);
  localparam logic [4:0]  CMD_AD = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMDW, S_WAITNMI, S_XFER, S_STOPW, S_FIN
  } state_t;

  state_t        state;
  logic [3:0]    len_q;
  logic          dir_q;
  logic [3:0]    idx;
  logic [TW-1:0] tmo;
  logic          nmi_q;
  logic          nmi_edge;
  logic [7:0]    rbuf [16];
  logic [7:0]    wbuf [16];

  assign nmi_edge = IO_NMI & ~nmi_q;
  assign RDAT     = rbuf[RADR];

  // Host-side write buffer; frozen while a transaction owns it.
  always_ff @(posedge CL) begin
    if (WWE && !BUSY) wbuf[WADR] <= WDAT;
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      len_q <= '0;
      dir_q <= 1'b0;
      idx   <= '0;
      tmo   <= '0;
      nmi_q <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      IO_CS <= 1'b0;
      IO_WR <= 1'b0;
      IO_AD <= '0;
      IO_DO <= '0;
      for (int i = 0; i < 16; i++) rbuf[i] <= 8'h00;
    end else begin
      nmi_q <= IO_NMI;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            len_q <= LEN;
            dir_q <= DIR;
            ERR   <= 1'b0;
            BUSY  <= 1'b1;
            IO_CS <= 1'b1;
            IO_WR <= 1'b1;
            IO_AD <= CMD_AD;
            IO_DO <= CMD;
            state <= S_CMDW;
          end
        end
        S_CMDW: begin
          IO_CS <= 1'b0;
          IO_WR <= 1'b0;
          if (len_q == 4'd0) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_FIN;
          end else begin
            tmo   <= '0;
            state <= S_WAITNMI;
          end
        end
        S_WAITNMI: begin
          if (nmi_edge) begin
            idx   <= '0;
            tmo   <= '0;
            IO_CS <= 1'b1;
            IO_WR <= dir_q;
            IO_AD <= 5'h00;
            if (dir_q) IO_DO <= wbuf[0];
            state <= S_XFER;
          end else if (tmo == TW'(NMI_TIMEOUT - 1)) begin
            ERR   <= 1'b1;
            tmo   <= '0;
            IO_CS <= 1'b1;
            IO_WR <= 1'b1;
            IO_AD <= CMD_AD;
            IO_DO <= STOP_CMD;
            state <= S_STOPW;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_XFER: begin
          if (!dir_q) rbuf[idx] <= IO_DI;
          if (idx == len_q - 4'd1) begin
            IO_CS <= 1'b1;
            IO_WR <= 1'b1;
            IO_AD <= CMD_AD;
            IO_DO <= STOP_CMD;
            state <= S_STOPW;
          end else begin
            idx   <= idx + 4'd1;
            IO_AD <= {1'b0, idx + 4'd1};
            if (dir_q) IO_DO <= wbuf[idx + 4'd1];
          end
        end
        S_STOPW: begin
          IO_CS <= 1'b0;
          IO_WR <= 1'b0;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_FIN;
        end
        S_FIN: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digdug_cusio_master.sv
// Self-checking bench: directed scenarios plus randomized transactions against
// a transaction-level model of the bus sequence, latency and buffers.
module tb_digdug_cusio_master;

  localparam int unsigned TMO  = 4095;
  localparam logic [7:0]  STOP = 8'h10;

  logic       CL, RESET, REQ, DIR, WWE, BUSY, DONE, ERR, IO_CS, IO_WR, IO_NMI;
  logic [7:0] CMD, WDAT, RDAT, IO_DO, IO_DI;
  logic [3:0] LEN, WADR, RADR;
  logic [4:0] IO_AD;

  typedef struct packed {
    logic       wr;
    logic [4:0] ad;
    logic [7:0] d;
    logic       chk_d;
  } bus_t;

  bus_t       exp_q[$];
  bus_t       got_q[$];
  logic [7:0] wbuf_m[16];
  logic [7:0] rbuf_m[16];
  logic [7:0] io_mem[16];
  logic [7:0] io_wr_mem[16];
  int         checks = 0;
  int         errors = 0;

  digdug_cusio_master #(.STOP_CMD(STOP), .NMI_TIMEOUT(TMO)) dut (
    .CL(CL), .RESET(RESET), .REQ(REQ), .CMD(CMD), .LEN(LEN), .DIR(DIR),
    .WWE(WWE), .WADR(WADR), .WDAT(WDAT), .RADR(RADR), .RDAT(RDAT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .IO_CS(IO_CS), .IO_WR(IO_WR),
    .IO_AD(IO_AD), .IO_DO(IO_DO), .IO_DI(IO_DI), .IO_NMI(IO_NMI)
  );

  // I/O chip model: read data is a register file addressed by the bus.
  assign IO_DI = io_mem[IO_AD[3:0]];

  initial CL = 1'b0;
  always #5 CL = ~CL;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rbuf();
    for (int i = 0; i < 16; i++) begin
      RADR = 4'(i);
      #1;
      check($sformatf("rbuf[%0d]", i), 32'(RDAT), 32'(rbuf_m[i]));
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    WWE = 1'b1; WADR = a; WDAT = d;
    @(posedge CL); #1;
    WWE = 1'b0;
    wbuf_m[a] = d;
  endtask

  // Called just after a rising edge; REQ is presented in the current cycle.
  task automatic run_txn(input logic [7:0] cmd, input logic [3:0] len, input logic dir,
                         input int k, input bit nmi_en, input bit pre_high, input bit noise);
    int   exp_done, done_cyc, cyc, n;
    bit   exp_err;
    bus_t e;
    exp_q.delete();
    got_q.delete();
    e = '{1'b1, 5'h10, cmd, 1'b1};
    exp_q.push_back(e);
    if (len != 4'd0) begin
      if (nmi_en) begin
        for (int i = 0; i < int'(len); i++) begin
          e = '{dir, 5'(i), (dir ? wbuf_m[i] : 8'h00), dir};
          exp_q.push_back(e);
          if (!dir) rbuf_m[i] = io_mem[i];
        end
      end
      e = '{1'b1, 5'h10, STOP, 1'b1};
      exp_q.push_back(e);
    end
    exp_done = (len == 4'd0) ? 2 : (nmi_en ? int'(len) + k + 4 : int'(TMO) + 3);
    exp_err  = (len != 4'd0) && !nmi_en;

    REQ = 1'b1; CMD = cmd; LEN = len; DIR = dir;
    done_cyc = -1;
    cyc = 0;
    while (done_cyc < 0 && cyc < exp_done + 8) begin
      @(posedge CL); #1;
      cyc++;
      REQ    = (noise && cyc < exp_done) ? 1'($urandom) : 1'b0;
      WWE    = (noise && cyc < exp_done) ? 1'($urandom) : 1'b0;
      WADR   = 4'($urandom);
      WDAT   = 8'($urandom);
      IO_NMI = nmi_en && ((cyc == k + 2) || (pre_high && cyc <= 2));
      @(negedge CL);
      if (cyc == 1) check("busy_set", 32'(BUSY), 32'(1));
      if (IO_CS === 1'b1) begin
        e = '{IO_WR, IO_AD, IO_DO, 1'b1};
        got_q.push_back(e);
        if (IO_WR && !IO_AD[4]) io_wr_mem[IO_AD[3:0]] = IO_DO;
      end
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        check("err_at_done", 32'(ERR), 32'(exp_err));
      end
    end
    REQ = 1'b0; WWE = 1'b0; IO_NMI = 1'b0;
    check("done_latency", 32'(done_cyc), 32'(exp_done));
    check("bus_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("bus[%0d].wr_ad", i), 32'({got_q[i].wr, got_q[i].ad}),
            32'({exp_q[i].wr, exp_q[i].ad}));
      if (exp_q[i].chk_d) check($sformatf("bus[%0d].do", i), 32'(got_q[i].d), 32'(exp_q[i].d));
    end

    @(posedge CL); #1;
    @(negedge CL);
    check("done_pulse", 32'(DONE), 32'(0));
    check("busy_clear", 32'(BUSY), 32'(0));
    check("idle_cs", 32'(IO_CS), 32'(0));
    check("err_hold", 32'(ERR), 32'(exp_err));
    @(posedge CL); #1;
    @(negedge CL);
    check("no_requeue", 32'(BUSY), 32'(0));
    check_rbuf();
    @(posedge CL); #1;
  endtask

  initial begin
    RESET = 1'b1; REQ = 1'b0; CMD = '0; LEN = '0; DIR = 1'b0;
    WWE = 1'b0; WADR = '0; WDAT = '0; RADR = '0; IO_NMI = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rbuf_m[i] = 8'h00; io_mem[i] = 8'h00; io_wr_mem[i] = 8'h00; wbuf_m[i] = 8'h00;
    end
    repeat (2) @(posedge CL);
    #1;
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_done", 32'(DONE), 32'(0));
    check("rst_err", 32'(ERR), 32'(0));
    check("rst_bus", 32'({IO_CS, IO_WR, IO_AD, IO_DO}), 32'(0));
    check_rbuf();
    RESET = 1'b0;
    @(posedge CL); #1;

    for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));

    // Read with credits=0, P1 stick up
    io_mem[0] = 8'h00; io_mem[1] = 8'hF0; io_mem[2] = 8'hF8;
    run_txn(8'h71, 4'd3, 1'b0, int'($urandom_range(0, 10)), 1'b1, 1'b0, 1'b0);

    // Coinage setup write
    for (int i = 2; i <= 5; i++) host_write(4'(i), 8'h01);
    host_write(4'd8, 8'h00);
    run_txn(8'hC1, 4'd9, 1'b1, int'($urandom_range(0, 10)), 1'b1, 1'b0, 1'b0);
    check("creditat", 32'(io_wr_mem[2]), 32'(1));
    check("wr_mem8", 32'(io_wr_mem[8]), 32'(0));

    // No NMI: timeout, sticky ERR
    run_txn(8'hD2, 4'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CL);
    #1;
    check("err_sticky", 32'(ERR), 32'(1));

    // Command only
    run_txn(8'hA1, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // NMI already high on entry needs a fresh edge
    for (int i = 0; i < 16; i++) io_mem[i] = 8'($urandom);
    run_txn(8'h71, 4'd4, 1'b0, int'($urandom_range(3, 8)), 1'b1, 1'b1, 1'b0);

    // Randomized transactions, half with REQ/WWE noise while busy
    for (int t = 0; t < 6; t++) begin
      logic d;
      d = 1'($urandom);
      if (d) begin
        for (int j = 0; j < 4; j++) host_write(4'($urandom), 8'($urandom));
      end else begin
        for (int i = 0; i < 16; i++) io_mem[i] = 8'($urandom);
      end
      run_txn(8'($urandom), 4'($urandom_range(1, 15)), d,
              int'($urandom_range(0, 12)), 1'b1, 1'b0, 1'(t % 2));
    end
    run_txn(8'hC1, 4'd15, 1'b1, int'($urandom_range(0, 5)), 1'b1, 1'b0, 1'b0);

    // Reset during the XFER cycle at index 1
    for (int i = 0; i < 16; i++) io_mem[i] = 8'($urandom_range(1, 255));
    REQ = 1'b1; CMD = 8'h71; LEN = 4'd3; DIR = 1'b0;
    @(posedge CL); #1; REQ = 1'b0;
    @(posedge CL); #1; IO_NMI = 1'b1;
    @(posedge CL); #1; IO_NMI = 1'b0;
    @(posedge CL); #1;
    check("xfer_idx1", 32'({IO_CS, IO_AD}), 32'({1'b1, 5'h01}));
    RESET = 1'b1;
    #1;
    check("rst_cs", 32'(IO_CS), 32'(0));
    check("rst_wr", 32'(IO_WR), 32'(0));
    check("rst_busy_mid", 32'(BUSY), 32'(0));
    for (int i = 0; i < 16; i++) rbuf_m[i] = 8'h00;
    check_rbuf();
    @(posedge CL); #1;
    RESET = 1'b0;
    run_txn(8'hA1, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_txn(8'hC1, 4'd15, 1'b1, 2, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digdug_cusio_master.md
DIGDUG_CUSIO_MASTER -- requirements
Module: digdug_cusio_master

Interface
REQ-001 SHALL provide parameter STOP_CMD, default 8'h10, command byte written after every transfer; it disables the responder's NMI.
REQ-002 SHALL provide parameter NMI_TIMEOUT, default 4095, the maximum number of cycles spent waiting for an NMI rising edge.
REQ-003 SHALL have port CL  in  1  single clock; all state changes on posedge CL.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port REQ  in  1  start request, sampled in IDLE only.
REQ-006 SHALL have ports CMD in 8 (command byte), LEN in 4 (data transfer count, 0 means command only) and DIR in 1 (0 = read, 1 = write), all latched on an accepted REQ.
REQ-007 SHALL have ports WWE in 1, WADR in 4 and WDAT in 8, the host write port of the 16x8 write buffer.
REQ-008 SHALL have ports RADR in 4 and RDAT out 8, a combinational read of the 16x8 read buffer.
REQ-009 SHALL have ports BUSY out 1, DONE out 1 (one-cycle pulse) and ERR out 1 (sticky timeout flag).
REQ-010 SHALL have ports IO_CS out 1, IO_WR out 1, IO_AD out 5 and IO_DO out 8, all registered and driving the I/O chip select, write, address and data inputs.
REQ-011 SHALL have ports IO_DI in 8 (I/O chip data output) and IO_NMI in 1 (I/O chip NMI pulse).

Function
REQ-012 FSM states SHALL be IDLE, CMDW, WAITNMI, XFER, STOPW and FIN.
REQ-013 In IDLE with REQ=1, the block SHALL latch CMD, LEN and DIR, clear ERR, set BUSY and go to CMDW on that edge.
REQ-014 REQ in any state other than IDLE SHALL be ignored, with no queueing.
REQ-015 In CMDW (exactly one cycle), outputs SHALL be IO_CS=1, IO_WR=1, IO_AD=5'h10, IO_DO=latched CMD; next state SHALL be FIN if LEN=0, else WAITNMI.
REQ-016 In WAITNMI, IO_CS SHALL be 0 and a rising edge of IO_NMI SHALL be detected (IO_NMI=1 and the previous-cycle sample=0).
REQ-017 If IO_NMI is already high on entry to WAITNMI, the block SHALL require a fresh rising edge.
REQ-018 In WAITNMI, an NMI edge SHALL move the FSM to XFER with index=0 and reset the timeout counter.
REQ-019 If no edge arrives within NMI_TIMEOUT cycles, the block SHALL set ERR=1 and go to STOPW, skipping XFER.
REQ-020 XFER SHALL last exactly LEN cycles, one transfer per cycle, with IO_CS=1 and IO_AD={1'b0,index}.
REQ-021 For a read transfer (DIR=0), IO_WR SHALL be 0 and IO_DI SHALL be captured into rbuf[index] on the edge that ends the cycle in which IO_AD shows that index.
REQ-022 For a write transfer (DIR=1), IO_WR SHALL be 1 and IO_DO SHALL equal wbuf[index].
REQ-023 The transfer index SHALL be 4 bits; after index=LEN-1 the FSM SHALL go to STOPW, and the index SHALL never wrap.
REQ-024 In STOPW (one cycle), outputs SHALL be IO_CS=1, IO_WR=1, IO_AD=5'h10, IO_DO=STOP_CMD.
REQ-025 In FIN (one cycle), the block SHALL assert DONE=1, clear BUSY and return to IDLE on the next edge.
REQ-026 Latency for LEN=N≥1 with the NMI edge k cycles after WAITNMI entry SHALL be REQ to DONE = N+k+4 cycles.
REQ-027 Latency for LEN=0 SHALL be REQ to DONE = 2 cycles.
REQ-028 WWE SHALL write wbuf[WADR]=WDAT only while BUSY=0; WWE while BUSY=1 SHALL be ignored.
REQ-029 In IDLE, CMDW-excluded and WAITNMI cycles, IO_CS and IO_WR SHALL be 0, and IO_AD and IO_DO SHALL hold their last values.
REQ-030 ERR SHALL persist until the next accepted REQ or RESET.

Reset
REQ-031 RESET=1 SHALL asynchronously force state=IDLE, BUSY=0, DONE=0, ERR=0, IO_CS=0, IO_WR=0, IO_AD=0, IO_DO=0, index=0, timeout counter=0 and NMI sample=0.
REQ-032 RESET SHALL clear rbuf to 8'h00; wbuf contents are unaffected by RESET.
REQ-033 On RESET mid-transfer, the bus SHALL be released within the same cycle, no STOP_CMD is written, and a partially filled rbuf SHALL be cleared.
REQ-034 The first REQ after RESET release SHALL be accepted on the first rising edge at which RESET=0.

Verification
REQ-035 The bench SHALL cover: REQ, CMD=8'h71, LEN=3, DIR=0 against the I/O chip model with credits=0 and P1 stick up, then an NMI pulse -> rbuf[0..2]=00,F0 (ST_P1 stick up),F8; STOP write 8'h10 seen; DONE after N+k+4 cycles.
REQ-036 The bench SHALL cover: wbuf[2..5]=1,1,1,1 and wbuf[8]=0, CMD=8'hC1, LEN=9, DIR=1 -> 9 write cycles at AD 0..8, model CREDITAT=1, then STOP write.
REQ-037 The bench SHALL cover: CMD=8'hD2, LEN=2 with IO_NMI held 0 -> ERR=1 after 4095 WAITNMI cycles, no XFER cycles, STOP write then DONE.
REQ-038 The bench SHALL cover: LEN=0, CMD=8'hA1 -> a single command write, no STOP write, DONE 2 cycles after REQ.
REQ-039 The bench SHALL cover: REQ pulses and WWE during BUSY -> ignored, with wbuf unchanged and no second transaction.
REQ-040 The bench SHALL cover: RESET asserted during the XFER cycle at index 1 -> IO_CS=0 immediately, BUSY=0 and rbuf all 8'h00.
